mem_stage: RTL

- Memory-access stage of the 5-stage MIPS pipeline. Consumes the execute-stage results and holds the EX/MEM and MEM/WB pipeline registers.
- Drives the data-memory request/acknowledge handshake and stalls the pipeline while memory is busy.
- Is the source end of the forwarding interface: produces ALUoutMEM, regwriteaddrMEM, RegWriteMEM, regwritedataWB, regwriteaddrWB and RegWriteWB, which the execute-stage forwarding logic consumes.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/mem_stage_load_align.sv | 45 ++++
 rtl/mem_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, memory-stage FSM encoding
// and access-size codes used by the optional sub-word path (MEM_SUBWORD_EN).
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } memState_t;
endpackage

// File: rtl/mem_stage_load_align.sv
// Sub-word load extraction, store lane replication and alignment check.
// Compiled only when MEM_SUBWORD_EN is defined.
`ifdef MEM_SUBWORD_EN
module load_align
  import pipe_pkg::*;
(
  input  logic [1:0]        addrLow,
  input  logic [1:0]        memSize,
  input  logic              memSign,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] storeData,
  output logic [DATA_W-1:0] loadData,
  output logic [DATA_W-1:0] laneData,
  output logic [3:0]        byteEn,
  output logic              misaligned
);
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = rdata[{addrLow, 3'b000} +: 8];
  assign halfSel = addrLow[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    loadData   = rdata;
    laneData   = storeData;
    byteEn     = 4'b1111;
    misaligned = (addrLow != 2'b00);
    case (memSize)
      MEM_SIZE_BYTE: begin
        misaligned = 1'b0;
        byteEn     = 4'b0001 << addrLow;
        laneData   = {4{storeData[7:0]}};
        loadData   = {{24{memSign & byteSel[7]}}, byteSel};
      end
      MEM_SIZE_HALF: begin
        misaligned = addrLow[0];
        byteEn     = addrLow[1] ? 4'b1100 : 4'b0011;
        laneData   = {2{storeData[15:0]}};
        loadData   = {{16{memSign & halfSel[15]}}, halfSel};
      end
      default: ;
    endcase
  end
endmodule
`endif

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM and MEM/WB registers, data-memory handshake with
// ack timeout, forwarding sources. MEM_SUBWORD_EN adds half/byte accesses.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int                ACK_TIMEOUT       = 255,
  parameter logic [DATA_W-1:0] RESET_VECTOR_DATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ALUoutEX,
  input  logic [DATA_W-1:0] memwritedataEX,
  input  logic [REG_W-1:0]  regwriteaddrEX,
  input  logic              RegWriteEX,
  input  logic              MemReadEX,
  input  logic              MemWriteEX,
  input  logic              MemtoRegEX,
`ifdef MEM_SUBWORD_EN
  input  logic [1:0]        MemSizeEX,
  input  logic              MemSignEX,
  output logic [3:0]        dmem_be,
`endif
  output logic [DATA_W-1:0] ALUoutMEM,
  output logic [REG_W-1:0]  regwriteaddrMEM,
  output logic              RegWriteMEM,
  output logic              MemReadMEM,
  output logic [DATA_W-1:0] regwritedataWB,
  output logic [REG_W-1:0]  regwriteaddrWB,
  output logic              RegWriteWB,
  output logic              stallMEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              align_err,
  output logic              bus_err
);
  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

  logic [DATA_W-1:0] memwritedataMEM;
  logic              MemWriteMEM;
  logic              MemtoRegMEM;
  logic [DATA_W-1:0] loadData;
  logic              misaligned;
  logic              memOp;
  logic              accessDone;
  memState_t         stateReg, stateNext;
  logic [15:0]       cntReg, cntNext;

  // EX/MEM register: frozen while the memory access is outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUoutMEM       <= RESET_VECTOR_DATA;
      memwritedataMEM <= RESET_VECTOR_DATA;
      regwriteaddrMEM <= '0;
      RegWriteMEM     <= 1'b0;
      MemReadMEM      <= 1'b0;
      MemWriteMEM     <= 1'b0;
      MemtoRegMEM     <= 1'b0;
    end else if (!stallMEM) begin
      ALUoutMEM       <= ALUoutEX;
      memwritedataMEM <= memwritedataEX;
      regwriteaddrMEM <= regwriteaddrEX;
      RegWriteMEM     <= RegWriteEX;
      MemReadMEM      <= MemReadEX;
      MemWriteMEM     <= MemWriteEX;
      MemtoRegMEM     <= MemtoRegEX;
    end
  end

`ifdef MEM_SUBWORD_EN
  logic [1:0] memSizeMEM;
  logic       memSignMEM;

  always_ff @(posedge clk) begin
    if (reset) begin
      memSizeMEM <= MEM_SIZE_WORD;
      memSignMEM <= 1'b0;
    end else if (!stallMEM) begin
      memSizeMEM <= MemSizeEX;
      memSignMEM <= MemSignEX;
    end
  end

  load_align uAlign (
    .addrLow   (ALUoutMEM[1:0]),
    .memSize   (memSizeMEM),
    .memSign   (memSignMEM),
    .rdata     (dmem_rdata),
    .storeData (memwritedataMEM),
    .loadData  (loadData),
    .laneData  (dmem_wdata),
    .byteEn    (dmem_be),
    .misaligned(misaligned)
  );
`else
  assign loadData   = dmem_rdata;
  assign dmem_wdata = memwritedataMEM;
  assign misaligned = (ALUoutMEM[1:0] != 2'b00);
`endif

  assign memOp     = MemReadMEM | MemWriteMEM;
  assign dmem_addr = ALUoutMEM;
  assign dmem_we   = dmem_req & MemWriteMEM;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= MEM_IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    dmem_req   = 1'b0;
    stallMEM   = 1'b0;
    align_err  = 1'b0;
    bus_err    = 1'b0;
    accessDone = 1'b0;
    case (stateReg)
      MEM_IDLE: begin
        cntNext = '0;
        if (memOp) begin
          if (misaligned) begin
            align_err = 1'b1;
          end else begin
            dmem_req = 1'b1;
            if (dmem_ack) begin
              accessDone = 1'b1;
            end else begin
              stallMEM  = 1'b1;
              stateNext = MEM_WAIT;
            end
          end
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          accessDone = 1'b1;
          stateNext  = MEM_IDLE;
          cntNext    = '0;
        end else if (cntReg >= TIMEOUT_LAST) begin
          // abandoned access leaves as a bubble; stall drops this cycle
          bus_err   = 1'b1;
          stateNext = MEM_IDLE;
          cntNext   = '0;
        end else begin
          stallMEM = 1'b1;
          if (cntReg != 16'hFFFF) cntNext = cntReg + 16'd1;
        end
      end
      default: stateNext = MEM_IDLE;
    endcase
  end

  // MEM/WB register: memory ops that did not complete become bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteWB     <= 1'b0;
      regwriteaddrWB <= '0;
      regwritedataWB <= RESET_VECTOR_DATA;
    end else if (!memOp || accessDone) begin
      RegWriteWB     <= RegWriteMEM;
      regwriteaddrWB <= regwriteaddrMEM;
      regwritedataWB <= MemtoRegMEM ? loadData : ALUoutMEM;
    end else begin
      RegWriteWB <= 1'b0;
    end
  end
endmodule
